vec_unit_rr_scheduler: RTL and testbench
========================================

Name: vec_unit_rr_scheduler

Overview:
- Round-robin scheduler that shares one vector activation unit (v_leakyrelu-class, single-vector-in / single-vector-out) between NumReq requesting layer streams.
- Captures one requester's vector and pulses the unit start (in_data_ready-style).
- Waits for the unit's out-valid, then returns the result to the granted requester with a valid/read handshake.
- Sits between the per-channel v_fifo stages and the shared unit wrapper.

Parameters:
- NumReq, 4, number of requesters (>=1)
- VecElements, 16, elements per vector
- NBits, 12, bits per element
- TimeoutCycles, 256, watchdog limit in WAIT (used only with the macro)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; synchronous, active-low (rst_in=0 resets on the clk_in edge)
- req_valid  input  [NumReq-1:0]  requester i has a vector pending; held until req_ack[i]
- req_data  input  [NumReq-1:0][VecElements-1:0][NBits-1:0]  requester vectors
- req_ack  output  [NumReq-1:0]  one-cycle pulse, vector i captured
- unit_ready  input  1  shared unit idle (module_ready)
- unit_start  output  1  one-cycle start pulse to unit
- unit_data  output  [VecElements-1:0][NBits-1:0]  captured vector to unit
- unit_done  input  1  unit result valid (out_data_valid)
- unit_result  input  [VecElements-1:0][NBits-1:0]  unit output vector
- rsp_valid  output  [NumReq-1:0]  result pending for requester i (one-hot or zero)
- rsp_id  output  $clog2(NumReq) min 1  index of current response
- rsp_data  output  [VecElements-1:0][NBits-1:0]  result vector
- rsp_rd  input  1  consumer takes response this cycle
- busy  output  1  state != IDLE
- timeout_err  output  1  one-cycle pulse on watchdog abort (constant 0 without macro)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0; all outputs 0 (req_ack, unit_start, unit_data, rsp_valid, rsp_id, rsp_data, busy, timeout_err).
- States: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
- IDLE
  - At an edge where |req_valid and unit_ready=1, grant g = first i with req_valid[i], searching circularly from rr_ptr.
  - Latch req_data[g] into unit_data and g into the internal grant register; go to ISSUE.
  - If unit_ready=0, stay in IDLE; no grant, no ack.
- ISSUE
  - req_ack[g]=1 and unit_start=1 for exactly this one cycle (both registered, set on the grant edge).
  - Next state WAIT.
- WAIT
  - On unit_done=1, latch unit_result into rsp_data, set rsp_valid[g]=1 and rsp_id=g; go to HOLD.
  - unit_done in IDLE, ISSUE or HOLD is ignored.
- HOLD
  - rsp_valid/rsp_id/rsp_data held stable while rsp_rd=0.
  - On rsp_rd=1: clear rsp_valid, rr_ptr=(g+1) mod NumReq, go to IDLE.
  - The next grant is decided no earlier than the edge after the rsp_rd edge.
- Latency: grant edge k -> req_ack/unit_start high in cycle k+1; unit_done sampled at edge m -> rsp_valid high from cycle m+1.
- unit_data stays stable from the grant edge until the next grant (unit may sample late).
- A requester dropping req_valid before its grant edge is not served. req_valid[g] remaining high after ack is treated as a new request.
- rsp_rd with no rsp_valid: ignored.
- Fairness: the requester just served has lowest priority next round. With all NumReq valid, grants cycle 0,1,2,...,NumReq-1,0.
- NumReq=1: rr_ptr stays 0; rsp_id is 1 bit, always 0.
- Reset mid-operation: everything returns to reset values at that edge.
  - In-flight vector discarded; pending rsp_valid cleared.
  - An ack already issued is not repeated.
  - A unit_done arriving after reset is ignored (state IDLE).

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT, incremented each WAIT cycle.
  - If it reaches TimeoutCycles with no unit_done: pulse timeout_err one cycle, leave rsp_valid=0, rr_ptr=(g+1) mod NumReq, go to IDLE. The request is dropped, not retried.
  - unit_done on the same edge as the limit wins (normal completion, no error).
- Undefined: no counter; WAIT waits indefinitely; timeout_err tied 0.

Test Plan:
- Reset then single request: NumReq=4, req_valid=4'b0100, unit_ready=1, all elements of req_data[2]=12'h0F3 -> req_ack=4'b0100 and unit_start one cycle together, unit_data=all 12'h0F3; unit_done with unit_result all 12'h0F3 -> rsp_valid=4'b0100, rsp_id=2; rsp_rd -> rsp_valid=0, busy=0.
- Round-robin: req_valid=4'b1111 held, each request completed and read -> ack order 0,1,2,3,0; no requester granted twice in a row while others wait.
- Back-pressure: rsp_rd held 0 for 20 cycles after unit_done -> rsp_data/rsp_id stable; no new grant or unit_start until the rsp_rd edge.
- Unit busy: unit_ready=0 with req_valid=4'b0001 for 10 cycles -> no ack/start; unit_ready=1 -> grant on the next edge.
- Reset mid-WAIT: rst_in=0 one cycle during WAIT, then unit_done=1 -> all outputs 0, no rsp_valid, rr_ptr=0.
- SCHED_TIMEOUT_EN, TimeoutCycles=8: grant, no unit_done -> timeout_err pulse after 8 WAIT cycles, rsp_valid stays 0, next grant goes to the next requester in round-robin order.

Source files
------------

// File: rtl/vec_unit_rr_scheduler.sv
// Round-robin arbiter sharing one vector activation unit among NumReq streams.
// Optional watchdog on the unit response: define SCHED_TIMEOUT_EN.
module vec_unit_rr_scheduler #(
  parameter int NumReq        = 4,
  parameter int VecElements   = 16,
  parameter int NBits         = 12,
  parameter int TimeoutCycles = 256,
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic [NumReq-1:0]                        req_valid,
  input  logic [NumReq-1:0][VecElements-1:0][NBits-1:0] req_data,
  output logic [NumReq-1:0]                        req_ack,
  input  logic                                     unit_ready,
  output logic                                     unit_start,
  output logic [VecElements-1:0][NBits-1:0]        unit_data,
  input  logic                                     unit_done,
  input  logic [VecElements-1:0][NBits-1:0]        unit_result,
  output logic [NumReq-1:0]                        rsp_valid,
  output logic [IdW-1:0]                           rsp_id,
  output logic [VecElements-1:0][NBits-1:0]        rsp_data,
  input  logic                                     rsp_rd,
  output logic                                     busy,
  output logic                                     timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IdW-1:0] rr_ptr;
  logic [IdW-1:0] grant;
  logic [IdW-1:0] gnt_idx;
  logic           gnt_found;
  logic           do_grant;
  logic           do_done;
  logic           do_tmo;
  logic           do_rel;
  logic           tmo_hit;

  function automatic logic [IdW-1:0] wrap_add(
    input logic [IdW-1:0] p,
    input int             k
  );
    return IdW'((int'(p) + k) % NumReq);
  endfunction

  // Circular search starting at rr_ptr; the last served stream sits at the end.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!gnt_found && req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] tmo_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + CntW'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == CntW'(TimeoutCycles - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_tmo    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gnt_found && unit_ready) begin
          do_grant  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (unit_done) begin
          do_done   = 1'b1;
          state_nxt = S_HOLD;
        end else if (tmo_hit) begin
          do_tmo    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (rsp_rd) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign do_rel = ((state == S_HOLD) && rsp_rd) || do_tmo;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rr_ptr      <= '0;
      grant       <= '0;
      req_ack     <= '0;
      unit_start  <= 1'b0;
      unit_data   <= '0;
      rsp_valid   <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_ack     <= '0;
      unit_start  <= 1'b0;
      timeout_err <= do_tmo;
      if (do_grant) begin
        grant      <= gnt_idx;
        unit_data  <= req_data[gnt_idx];
        req_ack    <= NumReq'(1) << gnt_idx;
        unit_start <= 1'b1;
      end
      if (do_done) begin
        rsp_data  <= unit_result;
        rsp_id    <= grant;
        rsp_valid <= NumReq'(1) << grant;
      end
      if (do_rel) begin
        rsp_valid <= '0;
        rr_ptr    <= wrap_add(grant, 1);
      end
    end
  end

endmodule

// File: tb/tb_vec_unit_rr_scheduler.sv
// Bench for vec_unit_rr_scheduler: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
`timescale 1ns/1ps
module tb_vec_unit_rr_scheduler;
  localparam int NR = 4;
  localparam int VE = 16;
  localparam int NB = 12;
  localparam int TC = 8;
  localparam int IW = 2;
  typedef logic [VE-1:0][NB-1:0] vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic [NR-1:0] req_valid;
  logic [NR-1:0][VE-1:0][NB-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic unit_ready;
  logic unit_start;
  vec_t unit_data;
  logic unit_done;
  vec_t unit_result;
  logic [NR-1:0] rsp_valid;
  logic [IW-1:0] rsp_id;
  vec_t rsp_data;
  logic rsp_rd;
  logic busy;
  logic timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int rr = 0;

  vec_unit_rr_scheduler #(
    .NumReq(NR), .VecElements(VE), .NBits(NB), .TimeoutCycles(TC)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .unit_ready(unit_ready), .unit_start(unit_start),
    .unit_data(unit_data), .unit_done(unit_done),
    .unit_result(unit_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t fill_vec(input logic [NB-1:0] x);
    vec_t v;
    for (int e = 0; e < VE; e++) v[e] = x;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int e = 0; e < VE; e++) v[e] = NB'($urandom);
    return v;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic wait_ack(output int g, output bit ok);
    g = -1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (|req_ack) begin
        for (int i = 0; i < NR; i++) if (req_ack[i]) g = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_unit(input vec_t r, input int dly);
    @(negedge clk_in);
    repeat (dly) @(negedge clk_in);
    unit_result = r;
    unit_done = 1'b1;
    @(negedge clk_in);
    unit_done = 1'b0;
  endtask

  task automatic read_rsp();
    rsp_rd = 1'b1;
    @(negedge clk_in);
    rsp_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    req_valid = '0;
    req_data = '0;
    unit_ready = 1'b1;
    unit_done = 1'b0;
    unit_result = '0;
    rsp_rd = 1'b0;
    repeat (3) @(negedge clk_in);
    n_vec++;
    if ({req_ack, unit_start, rsp_valid, rsp_id, busy, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ack=%b st=%b rv=%b id=%0d busy=%b to=%b want 0",
               req_ack, unit_start, rsp_valid, rsp_id, busy, timeout_err);
    end
    n_vec++;
    if (unit_data !== '0 || rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got ud=%h rd=%h want 0", unit_data, rsp_data);
    end
    rst_in = 1'b1;
    rr = 0;
  endtask

  task automatic test_single();
    int g;
    bit ok;
    vec_t v;
    v = fill_vec(12'h0F3);
    for (int i = 0; i < NR; i++) req_data[i] = rand_vec();
    req_data[2] = v;
    req_valid = 4'b0100;
    wait_ack(g, ok);
    n_vec++;
    if (!ok || req_ack !== 4'b0100 || unit_start !== 1'b1 || unit_data !== v) begin
      n_err++;
      $display("FAIL single_issue: got ok=%b ack=%b st=%b ud=%h want ack=0100 st=1 ud=%h",
               ok, req_ack, unit_start, unit_data, v);
    end
    req_valid = '0;
    @(negedge clk_in);
    n_vec++;
    if (req_ack !== '0 || unit_start !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_pulse: got ack=%b st=%b busy=%b want 0 0 1",
               req_ack, unit_start, busy);
    end
    unit_result = v;
    unit_done = 1'b1;
    @(negedge clk_in);
    unit_done = 1'b0;
    n_vec++;
    if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_data !== v) begin
      n_err++;
      $display("FAIL single_rsp: got rv=%b id=%0d rd=%h want 0100 2 %h",
               rsp_valid, rsp_id, rsp_data, v);
    end
    read_rsp();
    n_vec++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_read: got rv=%b busy=%b want 0 0", rsp_valid, busy);
    end
    rr = 3;
  endtask

  task automatic test_round_robin();
    int g;
    int prev;
    int exp;
    bit ok;
    vec_t r;
    int order [5] = '{0, 1, 2, 3, 0};
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    rr = 0;
    prev = -1;
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp = pick(req_valid, rr);
      wait_ack(g, ok);
      n_vec++;
      if (!ok || g !== exp || g !== order[t] || g == prev) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got ok=%b g=%0d want %0d", t, ok, g, order[t]);
      end
      r = rand_vec();
      finish_unit(r, t);
      n_vec++;
      if (rsp_id !== IW'(exp) || rsp_data !== r || rsp_valid !== onehot(exp)) begin
        n_err++;
        $display("FAIL rr_rsp[%0d]: got id=%0d rv=%b want id=%0d", t, rsp_id, rsp_valid, exp);
      end
      read_rsp();
      prev = g;
      rr = (exp + 1) % NR;
    end
    req_valid = '0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_back_pressure();
    int g;
    int exp;
    bit ok;
    vec_t r;
    int bad;
    req_valid = 4'b1111;
    exp = pick(req_valid, rr);
    wait_ack(g, ok);
    r = rand_vec();
    finish_unit(r, 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid !== onehot(exp) || rsp_id !== IW'(exp) || rsp_data !== r ||
          req_ack !== '0 || unit_start !== 1'b0)
        bad++;
      @(negedge clk_in);
    end
    n_vec++;
    if (!ok || g !== exp || bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: got g=%0d bad_cycles=%0d want g=%0d bad_cycles=0", g, bad, exp);
    end
    read_rsp();
    rr = (exp + 1) % NR;
    n_vec++;
    if (req_ack !== '0 || rsp_valid !== '0) begin
      n_err++;
      $display("FAIL bp_early: got ack=%b rv=%b want 0 0", req_ack, rsp_valid);
    end
    exp = pick(req_valid, rr);
    @(negedge clk_in);
    n_vec++;
    if (req_ack !== onehot(exp) || unit_start !== 1'b1) begin
      n_err++;
      $display("FAIL bp_next: got ack=%b st=%b want %b 1", req_ack, unit_start, onehot(exp));
    end
    req_valid = '0;
    finish_unit(rand_vec(), 0);
    read_rsp();
    rr = (exp + 1) % NR;
  endtask

  task automatic test_unit_busy();
    int bad;
    unit_ready = 1'b0;
    req_valid = 4'b0001;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (req_ack !== '0 || unit_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL busy_block: got bad_cycles=%0d want 0", bad);
    end
    unit_ready = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if (req_ack !== 4'b0001 || unit_start !== 1'b1) begin
      n_err++;
      $display("FAIL busy_release: got ack=%b st=%b want 0001 1", req_ack, unit_start);
    end
    req_valid = '0;
    finish_unit(rand_vec(), 2);
    read_rsp();
    rr = 1;
  endtask

  task automatic test_reset_mid_wait();
    int g;
    bit ok;
    req_valid = 4'b0110;
    wait_ack(g, ok);
    req_valid = '0;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    rr = 0;
    unit_result = rand_vec();
    unit_done = 1'b1;
    @(negedge clk_in);
    unit_done = 1'b0;
    n_vec++;
    if ({req_ack, unit_start, rsp_valid, rsp_id, busy, timeout_err} !== '0 ||
        unit_data !== '0 || rsp_data !== '0) begin
      n_err++;
      $display("FAIL rst_wait: got ack=%b st=%b rv=%b id=%0d busy=%b want all 0",
               req_ack, unit_start, rsp_valid, rsp_id, busy);
    end
    req_valid = 4'b1111;
    wait_ack(g, ok);
    n_vec++;
    if (!ok || g !== 0) begin
      n_err++;
      $display("FAIL rst_ptr: got ok=%b g=%0d want 0", ok, g);
    end
    req_valid = '0;
    finish_unit(rand_vec(), 0);
    read_rsp();
    rr = 1;
  endtask

  task automatic test_random();
    int g;
    int exp;
    bit ok;
    logic [NR-1:0] v;
    vec_t cap;
    vec_t r;
    for (int t = 0; t < 30; t++) begin
      v = NR'($urandom);
      if (v == '0) v = onehot($urandom_range(NR - 1));
      for (int i = 0; i < NR; i++) req_data[i] = rand_vec();
      req_valid = v;
      exp = pick(v, rr);
      cap = req_data[exp];
      wait_ack(g, ok);
      n_vec++;
      if (!ok || req_ack !== onehot(exp) || unit_start !== 1'b1 || unit_data !== cap) begin
        n_err++;
        $display("FAIL rand_grant[%0d]: got ok=%b ack=%b want ack=%b", t, ok, req_ack, onehot(exp));
      end
      req_valid = '0;
      for (int i = 0; i < NR; i++) req_data[i] = rand_vec();
      r = rand_vec();
      finish_unit(r, $urandom_range(4));
      n_vec++;
      if (unit_data !== cap || rsp_valid !== onehot(exp) ||
          rsp_id !== IW'(exp) || rsp_data !== r) begin
        n_err++;
        $display("FAIL rand_rsp[%0d]: got rv=%b id=%0d want rv=%b id=%0d",
                 t, rsp_valid, rsp_id, onehot(exp), exp);
      end
      repeat ($urandom_range(3)) @(negedge clk_in);
      read_rsp();
      rr = (exp + 1) % NR;
    end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int g;
    int exp;
    int n;
    bit ok;
    req_valid = 4'b1111;
    exp = pick(req_valid, rr);
    wait_ack(g, ok);
    req_valid = '0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_in);
      if (timeout_err === 1'b1) begin
        n = c;
        break;
      end
    end
    n_vec++;
    if (!ok || g !== exp || n != TC + 1 || rsp_valid !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout: got g=%0d at=%0d rv=%b busy=%b want g=%0d at=%0d rv=0 busy=0",
               g, n, rsp_valid, busy, exp, TC + 1);
    end
    rr = (exp + 1) % NR;
    req_valid = 4'b1111;
    @(negedge clk_in);
    n_vec++;
    if (timeout_err !== 1'b0 || req_ack !== onehot(pick(req_valid, rr))) begin
      n_err++;
      $display("FAIL timeout_next: got to=%b ack=%b want 0 %b",
               timeout_err, req_ack, onehot(pick(req_valid, rr)));
    end
    exp = pick(req_valid, rr);
    req_valid = '0;
    finish_unit(rand_vec(), 0);
    read_rsp();
    rr = (exp + 1) % NR;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_unit_busy();
    test_reset_mid_wait();
    test_random();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
